wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data width of write-back values and write_data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a_valid / a_ready  input / output  1 / 1  ALU write-back handshake.
REQ-005 a_rd / a_data  input  5 / XLEN  ALU destination register index / value.
REQ-006 b_valid / b_ready  input / output  1 / 1  load-unit write-back handshake.
REQ-007 b_rd / b_data  input  5 / XLEN  load-unit destination index / value.
REQ-008 iss_valid / iss_rd  input  1 / 5  issue marks iss_rd as pending write.
REQ-009 rs1i / rs2i  input  5 / 5  source indices being read from the register file this cycle.
REQ-010 hazard  output  1  combinational; source read this cycle would return a stale value.
REQ-011 rdi / write_data / reg_write  output  5 / XLEN / 1  registered write port driving the register file.

Function
REQ-012 Transfer on a requester = valid && ready at a rising edge; at most one transfer per cycle.
REQ-013 Ready combinational from valids and arbitration state: sole valid requester gets ready=1; with neither valid, both readys = 0.
REQ-014 Contention (a_valid && b_valid) default: fixed priority, b granted, a_ready = 0.
REQ-015 Accepted rd/data registered into rdi/write_data at the transfer edge; reg_write = 1 in the following cycle only, latency exactly 1 cycle.
REQ-016 Transfer with rd = 0: accepted (ready asserted normally), reg_write = 0 next cycle, rdi/write_data still updated.
REQ-017 No transfer in a cycle: reg_write = 0 next cycle; rdi/write_data hold.
REQ-018 Scoreboard busy[31:1]; busy[0] constant 0.
REQ-019 iss_valid with iss_rd != 0 sets busy[iss_rd] at the edge.
REQ-020 Transfer with rd != 0 clears busy[rd] at the transfer edge.
REQ-021 Set and clear of the same index at the same edge: busy ends 1 (new issue wins).
REQ-022 hazard = busy[rs1i] | busy[rs2i] | (reg_write && rdi != 0 && (rdi == rs1i || rdi == rs2i)); the last term covers the write-then-read collision in the synchronous register file.
REQ-023 rs index 0 never raises hazard.
REQ-024 Requester holding valid while not ready: no transfer, no state change for that requester.

Reset
REQ-025 rst asserted: reg_write = 0, rdi = 0, write_data = 0, busy all 0, round-robin pointer = "last granted a", immediately and asynchronously.
REQ-026 Reset mid-operation: in-flight registered write dropped (reg_write forced 0), pending busy bits lost; readys reflect valids combinationally during reset but no transfer state updates until rst deasserted.

Configuration
REQ-027 Macro WB_RR_EN defined: contention granted round-robin; requester not granted at the most recent contention wins; pointer updates only on contention-resolved transfers; first contention after reset grants b.
REQ-028 WB_RR_EN undefined: fixed priority per REQ-014, no pointer state.

Verification
REQ-029 Reset, then a_valid=1 a_rd=5 a_data=0x11 one cycle -> a_ready=1; next cycle reg_write=1 rdi=5 write_data=0x11; following cycle reg_write=0.
REQ-030 a and b valid 4 cycles (a_rd=1, b_rd=2): WB_RR_EN off -> b granted all 4, a_ready=0; WB_RR_EN on -> grants b,a,b,a.
REQ-031 b_valid b_rd=0 b_data=0xFF -> b_ready=1; next cycle reg_write=0, rdi=0.
REQ-032 iss_valid iss_rd=7; then rs1i=7 -> hazard=1; a writes rd 7 -> same cycle busy cleared, next cycle hazard=1 (reg_write collision), cycle after hazard=0.
REQ-033 iss_rd=9 and write-back rd=9 same edge -> busy[9]=1, hazard with rs2i=9 stays 1.
REQ-034 rst pulse while reg_write=1 rdi=3 and busy[4]=1 -> reg_write=0, hazard=0 for rs1i=4 immediately.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter with scoreboard hazard detection and a registered
// register-file write port. Define WB_RR_EN for round-robin contention grants.
module wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1i,
    input  logic [4:0]      rs2i,
    output logic            hazard,
    output logic [4:0]      rdi,
    output logic [XLEN-1:0] write_data,
    output logic            reg_write
);

    logic [31:1]     busy_q;
    logic [31:1]     busy_next;
    logic [31:0]     busy_vec;
    logic            grant_b_on_cont;
    logic            contention;
    logic            xfer;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            wb_collide;

`ifdef WB_RR_EN
    // Set when b won the most recent contention; the other side wins next time.
    logic last_b_q;
    assign grant_b_on_cont = !last_b_q;
`else
    assign grant_b_on_cont = 1'b1;
`endif

    assign contention = a_valid && b_valid;
    assign b_ready    = b_valid && (!a_valid || grant_b_on_cont);
    assign a_ready    = a_valid && (!b_valid || !grant_b_on_cont);
    assign xfer       = (a_valid && a_ready) || (b_valid && b_ready);
    assign sel_rd     = b_ready ? b_rd : a_rd;
    assign sel_data   = b_ready ? b_data : a_data;

    // NOTE: every bit gets a value on every path, so no latch is inferred;
    // the set term is OR-ed last so a same-edge issue overrides the clear.
    always_comb begin
        busy_next = '0;
        for (int i = 1; i < 32; i++) begin
            busy_next[i] = (busy_q[i] && !(xfer && sel_rd == 5'(i)))
                         || (iss_valid && iss_rd == 5'(i));
        end
    end

    assign busy_vec   = {busy_q, 1'b0};
    assign wb_collide = reg_write && (rdi != 5'd0) && (rdi == rs1i || rdi == rs2i);
    assign hazard     = busy_vec[rs1i] || busy_vec[rs2i] || wb_collide;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write  <= 1'b0;
            rdi        <= '0;
            write_data <= '0;
            busy_q     <= '0;
`ifdef WB_RR_EN
            last_b_q   <= 1'b0;
`endif
        end else begin
            reg_write <= xfer && (sel_rd != 5'd0);
            if (xfer) begin
                rdi        <= sel_rd;
                write_data <= sel_data;
            end
            busy_q <= busy_next;
`ifdef WB_RR_EN
            if (xfer && contention)
                last_b_q <= b_ready;
`endif
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: write-port scoreboard plus per-scenario
// handshake and hazard checks. Honours WB_RR_EN for contention expectations.
module tb_wb_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid, b_valid, iss_valid;
    logic            a_ready, b_ready;
    logic [4:0]      a_rd, b_rd, iss_rd, rs1i, rs2i;
    logic [XLEN-1:0] a_data, b_data;
    logic            hazard, reg_write;
    logic [4:0]      rdi;
    logic [XLEN-1:0] write_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            rw;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_exp_t;

    wb_exp_t         sb_q[$];
    wb_exp_t         mon_e;
    logic [4:0]      last_rd;
    logic [XLEN-1:0] last_data;

    wb_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1i(rs1i), .rs2i(rs2i),
        .hazard(hazard), .rdi(rdi), .write_data(write_data), .reg_write(reg_write)
    );

    always #5 clk = ~clk;

    // Entries pushed at a negedge describe the write port after the next posedge.
    always @(posedge clk) begin
        #1;
        if (!rst && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (reg_write !== mon_e.rw || rdi !== mon_e.rd || write_data !== mon_e.data) begin
                errors++;
                $display("FAIL wb_port: got rw=%0b rdi=%0d data=%h, expected rw=%0b rdi=%0d data=%h",
                         reg_write, rdi, write_data, mon_e.rw, mon_e.rd, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [XLEN-1:0] bd,
                         input logic iv, input logic [4:0] ird);
        @(negedge clk);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        iss_valid = iv; iss_rd = ird;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    endtask

    task automatic push_wr(input logic [4:0] rd, input logic [XLEN-1:0] data);
        wb_exp_t e;
        e.rw = (rd != 5'd0); e.rd = rd; e.data = data;
        last_rd = rd; last_data = data;
        sb_q.push_back(e);
    endtask

    task automatic push_idle();
        wb_exp_t e;
        e.rw = 1'b0; e.rd = last_rd; e.data = last_data;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 8) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        last_rd = '0; last_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
        a_rd = '0; b_rd = '0; iss_rd = '0; a_data = '0; b_data = '0;
        rs1i = '0; rs2i = '0;
        last_rd = '0; last_data = '0;
        #1;
        checks++;
        if (reg_write !== 1'b0 || rdi !== 5'd0 || write_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rw=%0b rdi=%0d data=%h, expected 0/0/0", reg_write, rdi, write_data);
        end
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h55;
        iss_valid = 1'b1; iss_rd = 5'd6; rs1i = 5'd6;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got a_ready=%0b b_ready=%0b, expected 1/0", a_ready, b_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (reg_write !== 1'b0 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got rw=%0b hazard=%0b, expected 0/0", reg_write, hazard);
        end
        @(negedge clk);
        a_valid = 1'b0; iss_valid = 1'b0; rs1i = '0;
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got a_ready=%0b b_ready=%0b, expected 1/0", a_ready, b_ready);
        end
        push_wr(5'd5, 32'h11);
        idle(); push_idle();
        idle(); push_idle();
        drain();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd10, 32'hA10, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        push_wr(5'd10, 32'hA10);
        drive(1'b0, 5'd0, '0, 1'b1, 5'd11, 32'hB11, 1'b0, 5'd0);
        #1;
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready: got a_ready=%0b b_ready=%0b, expected 0/1", a_ready, b_ready);
        end
        push_wr(5'd11, 32'hB11);
        drive(1'b1, 5'd12, 32'hA12, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        push_wr(5'd12, 32'hA12);
        idle(); push_idle();
        drain();
    endtask

    task automatic test_contention();
        logic exp_b;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 32'hA000 + XLEN'(i), 1'b1, 5'd2, 32'hB000 + XLEN'(i), 1'b0, 5'd0);
`ifdef WB_RR_EN
            exp_b = (i % 2 == 0);
`else
            exp_b = 1'b1;
`endif
            #1;
            checks++;
            if (b_ready !== exp_b || a_ready !== !exp_b) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got a_ready=%0b b_ready=%0b, expected %0b/%0b",
                         i, a_ready, b_ready, !exp_b, exp_b);
            end
            if (exp_b) push_wr(5'd2, 32'hB000 + XLEN'(i));
            else       push_wr(5'd1, 32'hA000 + XLEN'(i));
        end
        idle(); push_idle();
        drain();
    endtask

    task automatic test_rd_zero();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hFF, 1'b1, 5'd0);
        #1;
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd0_ready: got b_ready=%0b, expected 1", b_ready);
        end
        push_wr(5'd0, 32'hFF);
        idle(); push_idle();
        rs1i = 5'd0; rs2i = 5'd0;
        #1;
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL rd0_hazard: got hazard=%0b, expected 0", hazard);
        end
        drain();
    endtask

    task automatic test_hazard_clear();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7);
        push_idle();
        idle();
        rs1i = 5'd7;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL haz_busy: got hazard=%0b, expected 1", hazard);
        end
        push_idle();
        drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        push_wr(5'd7, 32'h77);
        @(posedge clk); #2;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL haz_collide: got hazard=%0b, expected 1", hazard);
        end
        idle(); push_idle();
        @(posedge clk); #2;
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL haz_cleared: got hazard=%0b, expected 0", hazard);
        end
        rs1i = 5'd0;
        drain();
    endtask

    task automatic test_same_edge();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9);
        push_idle();
        drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, '0, 1'b1, 5'd9);
        rs2i = 5'd9;
        push_wr(5'd9, 32'h99);
        idle(); push_idle();
        idle(); push_idle();
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL same_edge_busy: got hazard=%0b, expected 1", hazard);
        end
        drive(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h9A, 1'b0, 5'd0);
        push_wr(5'd9, 32'h9A);
        idle(); push_idle();
        idle(); push_idle();
        #1;
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_release: got hazard=%0b, expected 0", hazard);
        end
        rs2i = 5'd0;
        drain();
    endtask

    task automatic test_reset_mid_op();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, '0, 1'b1, 5'd4);
        push_wr(5'd3, 32'h33);
        @(posedge clk); #3;
        rs1i = 5'd4;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got hazard=%0b, expected 1", hazard);
        end
        rst = 1'b1;
        a_valid = 1'b1; a_rd = 5'd8; a_data = 32'h88;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h44;
        iss_valid = 1'b1; iss_rd = 5'd4;
        #1;
        checks++;
        if (reg_write !== 1'b0 || hazard !== 1'b0 || rdi !== 5'd0 || write_data !== '0) begin
            errors++;
            $display("FAIL midrst_async: got rw=%0b hazard=%0b rdi=%0d data=%h, expected 0/0/0/0",
                     reg_write, hazard, rdi, write_data);
        end
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready: got a_ready=%0b b_ready=%0b, expected 0/1", a_ready, b_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (reg_write !== 1'b0 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL midrst_frozen: got rw=%0b hazard=%0b, expected 0/0", reg_write, hazard);
        end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0; rs1i = '0;
        rst = 1'b0;
        sb_q.delete();
        last_rd = '0; last_data = '0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_contention();
        test_rd_zero();
        test_hazard_clear();
        test_same_edge();
        test_reset_mid_op();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
